// File: rtl/program_loader.sv
// Byte-stream program loader: receives a length-prefixed, XOR-checksummed frame
// and writes it word by word into program RAM while holding the CPU.
module program_loader #(
   parameter int DEPTH   = 32768,
   parameter int TIMEOUT = 1000000
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic [14:0] ram_address,
   output logic [15:0] ram_data,
   output logic        ram_wren,
   output logic        cpu_hold,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code
);

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);
   localparam logic [31:0] TMO_W   = 32'(TIMEOUT);
   localparam logic        TMO_EN  = (TIMEOUT != 0);

   localparam logic [1:0] CODE_CSUM = 2'b01;
   localparam logic [1:0] CODE_LEN  = 2'b10;
   localparam logic [1:0] CODE_TMO  = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA_LO,
      S_DATA_HI,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_t;

   state_t      state_q;
   logic [7:0]  lo_q;
   logic [15:0] len_q;
   logic [15:0] idx_q;
   logic [7:0]  csum_q;
   logic [31:0] tmr_q;
   logic [14:0] ram_address_q;
   logic [15:0] ram_data_q;
   logic        ram_wren_q;
   logic        done_q;
   logic        err_q;
   logic [1:0]  err_code_q;

   logic        rx_ready_d;
   logic        accept_d;
   logic [15:0] len_d;
   logic [15:0] idx_d;
   logic [31:0] tmr_d;
   logic        tmo_hit_d;

   always_comb begin
      rx_ready_d = 1'b0;
      case (state_q)
         S_LEN_LO, S_LEN_HI, S_DATA_LO, S_DATA_HI, S_CHECK: rx_ready_d = 1'b1;
         default:                                           rx_ready_d = 1'b0;
      endcase
   end

   assign accept_d  = rx_valid && rx_ready_d;
   assign len_d     = {rx_data, lo_q};
   assign idx_d     = idx_q + 16'd1;
   assign tmr_d     = tmr_q + 32'd1;
   // An accepted byte always wins over an expiring idle counter in the same cycle.
   assign tmo_hit_d = TMO_EN && rx_ready_d && !accept_d && (tmr_d == TMO_W);

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         lo_q          <= 8'd0;
         len_q         <= 16'd0;
         idx_q         <= 16'd0;
         csum_q        <= 8'd0;
         tmr_q         <= 32'd0;
         ram_address_q <= 15'd0;
         ram_data_q    <= 16'd0;
         ram_wren_q    <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         err_code_q    <= 2'b00;
      end else begin
         if (rx_ready_d) begin
            tmr_q <= accept_d ? 32'd0 : tmr_d;
         end
         // The checksum byte itself is consumed in CHECK and never folded in.
         if (accept_d && state_q != S_CHECK) begin
            csum_q <= csum_q ^ rx_data;
         end

         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  state_q    <= S_LEN_LO;
                  done_q     <= 1'b0;
                  err_q      <= 1'b0;
                  err_code_q <= 2'b00;
                  idx_q      <= 16'd0;
                  csum_q     <= 8'd0;
                  tmr_q      <= 32'd0;
               end
            end
            S_LEN_LO: begin
               if (accept_d) begin
                  lo_q    <= rx_data;
                  state_q <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (accept_d) begin
                  len_q <= len_d;
                  if ({16'd0, len_d} > DEPTH_W) begin
                     state_q    <= S_ERR;
                     err_q      <= 1'b1;
                     err_code_q <= CODE_LEN;
                  end else if (len_d == 16'd0) begin
                     state_q <= S_CHECK;
                  end else begin
                     state_q <= S_DATA_LO;
                  end
               end
            end
            S_DATA_LO: begin
               if (accept_d) begin
                  lo_q    <= rx_data;
                  state_q <= S_DATA_HI;
               end
            end
            S_DATA_HI: begin
               if (accept_d) begin
                  ram_wren_q    <= 1'b1;
                  ram_address_q <= idx_q[14:0];
                  ram_data_q    <= {rx_data, lo_q};
                  state_q       <= S_WRITE;
               end
            end
            S_WRITE: begin
               ram_wren_q <= 1'b0;
               idx_q      <= idx_d;
               state_q    <= (idx_d == len_q) ? S_CHECK : S_DATA_LO;
            end
            S_CHECK: begin
               if (accept_d) begin
                  if (rx_data == csum_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q    <= S_ERR;
                     err_q      <= 1'b1;
                     err_code_q <= CODE_CSUM;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase

         if (tmo_hit_d) begin
            state_q    <= S_ERR;
            err_q      <= 1'b1;
            err_code_q <= CODE_TMO;
         end
      end
   end

   assign rx_ready    = rx_ready_d;
   assign ram_address = ram_address_q;
   assign ram_data    = ram_data_q;
   assign ram_wren    = ram_wren_q;
   assign cpu_hold    = (state_q != S_DONE);
   assign done        = done_q;
   assign err         = err_q;
   assign err_code    = err_code_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomised frame bench for program_loader with a frame-level expectation model
// (checksum, length, timeout and write list derived from the byte stream).
module tb_program_loader;

   localparam int DEPTH = 4;
   localparam int TMO   = 16;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        start;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic [14:0] ram_address;
   logic [15:0] ram_data;
   logic        ram_wren;
   logic        cpu_hold;
   logic        done;
   logic        err;
   logic [1:0]  err_code;

   int vectors     = 0;
   int miscompares = 0;

   logic [30:0] obs_q[$];
   logic [15:0] fw[$];
   logic [14:0] last_addr;
   logic [15:0] last_data;

   program_loader #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .ram_address(ram_address),
      .ram_data   (ram_data),
      .ram_wren   (ram_wren),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .err        (err),
      .err_code   (err_code)
   );

   always #10 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (ram_wren) obs_q.push_back({ram_address, ram_data});
   end

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit poke_start);
      int w;
      rx_valid = 1'b0;
      for (int i = 0; i < gap; i++) begin
         start = poke_start && ($urandom_range(0, 3) == 0);
         tick();
      end
      start    = 1'b0;
      rx_valid = 1'b1;
      rx_data  = b;
      w = 0;
      while (!rx_ready && w < 100) begin
         tick();
         w++;
      end
      if (!rx_ready) expect_eq("ready_wait", 32'(rx_ready), 32'd1);
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic check_state(input string tag, input bit exp_done, input logic [1:0] exp_code);
      expect_eq({tag, ".done"},     32'(done),     32'(exp_done));
      expect_eq({tag, ".err"},      32'(err),      32'(exp_code != 2'b00));
      expect_eq({tag, ".err_code"}, 32'(err_code), 32'(exp_code));
      expect_eq({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
      expect_eq({tag, ".rx_ready"}, 32'(rx_ready), 32'd0);
      expect_eq({tag, ".ram_addr"}, 32'(ram_address), 32'(last_addr));
      expect_eq({tag, ".ram_data"}, 32'(ram_data),    32'(last_data));
   endtask

   // gap_fix < 0 selects random inter-byte gaps (0..12) with stray start pulses.
   task automatic run_frame(input string name, input int n, input logic [7:0] ck_xor,
                            input int tmo_at_in, input int gap_fix);
      logic [7:0]  bytes[$];
      logic [30:0] exp_w[$];
      logic [7:0]  x;
      logic [1:0]  code;
      int sent, nw, tmo_at, w, gap;
      tmo_at = (n > DEPTH) ? -1 : tmo_at_in;
      bytes.push_back(8'(n));
      bytes.push_back(8'(n >> 8));
      if (n <= DEPTH) begin
         for (int i = 0; i < n; i++) begin
            bytes.push_back(fw[i][7:0]);
            bytes.push_back(fw[i][15:8]);
         end
      end
      x = 8'd0;
      foreach (bytes[k]) x = x ^ bytes[k];
      bytes.push_back(x ^ ck_xor);

      if (n > DEPTH) begin
         code = 2'b10; sent = 2; nw = 0;
      end else if (tmo_at >= 0 && tmo_at < bytes.size()) begin
         code = 2'b11; sent = tmo_at; nw = (tmo_at > 2) ? (tmo_at - 2) / 2 : 0;
      end else begin
         code = (ck_xor != 8'd0) ? 2'b01 : 2'b00; sent = bytes.size(); nw = n;
      end
      for (int i = 0; i < nw; i++) exp_w.push_back({15'(i), fw[i]});

      obs_q.delete();
      pulse_start();
      for (int k = 0; k < sent; k++) begin
         gap = (gap_fix >= 0) ? gap_fix : int'($urandom_range(0, 12));
         send_byte(bytes[k], gap, gap_fix < 0);
      end
      if (code == 2'b10) expect_eq({name, ".len_err_now"}, 32'({err, err_code}), 32'h6);
      if (code == 2'b11) repeat (TMO + 4) tick();
      w = 0;
      while (!(done || err) && w < 8) begin
         tick();
         w++;
      end
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      repeat (2) tick();
      rx_valid = 1'b0;

      if (nw > 0) begin
         last_addr = exp_w[nw-1][30:16];
         last_data = exp_w[nw-1][15:0];
      end
      check_state(name, code == 2'b00, code);
      expect_eq({name, ".nwrites"}, 32'(obs_q.size()), 32'(nw));
      for (int i = 0; i < nw && i < obs_q.size(); i++)
         expect_eq({name, ".wr"}, 32'(obs_q[i]), 32'(exp_w[i]));
      $display("frame %s: len=%0d bytes_sent=%0d expect_code=%0d writes=%0d",
               name, n, sent, code, nw);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ck;
      int n, tmo;
      reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
      last_addr = 15'd0; last_data = 16'd0;
      repeat (3) tick();
      check_state("reset", 1'b0, 2'b00);
      expect_eq("reset.wren", 32'(ram_wren), 32'd0);
      reset = 1'b0;
      tick();

      fw.delete(); fw.push_back(16'h1234); fw.push_back(16'h5678);
      run_frame("basic", 2, 8'h00, -1, -1);
      run_frame("bad_ck", 2, 8'h01, -1, -1);
      fw.delete();
      run_frame("empty", 0, 8'h00, -1, -1);
      run_frame("len_err", 5, 8'h00, -1, -1);

      fw.delete(); fw.push_back(16'hBEEF);
      pulse_start();
      send_byte(8'h01, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      repeat (15) tick();
      expect_eq("tmo15.err", 32'(err), 32'd0);
      tick();
      expect_eq("tmo16.err", 32'(err), 32'd1);
      expect_eq("tmo16.code", 32'(err_code), 32'd3);
      $display("frame tmo_exact: idle=16 err=%0d code=%0d", err, err_code);
      run_frame("tmo_edge", 1, 8'h00, -1, 15);

      fw.delete(); fw.push_back(16'hA5C3);
      obs_q.delete();
      pulse_start();
      send_byte(8'h01, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'hC3, 0, 1'b0);
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      #3 reset = 1'b1;
      #2;
      last_addr = 15'd0; last_data = 16'd0;
      check_state("rst_mid", 1'b0, 2'b00);
      expect_eq("rst_mid.wren", 32'(ram_wren), 32'd0);
      repeat (2) tick();
      reset = 1'b0;
      repeat (3) tick();
      expect_eq("rst_after.rx_ready", 32'(rx_ready), 32'd0);
      expect_eq("rst_after.nwrites", 32'(obs_q.size()), 32'd0);
      expect_eq("rst_after.cpu_hold", 32'(cpu_hold), 32'd1);
      rx_valid = 1'b0;
      $display("frame rst_mid: reset between DATA_LO and DATA_HI, writes=%0d", obs_q.size());
      run_frame("reload", 1, 8'h00, -1, -1);

      for (int r = 0; r < 40; r++) begin
         n = int'($urandom_range(0, 6));
         fw.delete();
         for (int i = 0; i < n; i++) fw.push_back(16'($urandom));
         ck  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
         tmo = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 2 + 2 * n)) : -1;
         run_frame($sformatf("rnd%0d", r), n, ck, tmo, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32768: program RAM depth in 16-bit words.
REQ-002 SHALL have parameter TIMEOUT, default 1000000: maximum idle cycles allowed between accepted bytes; 0 disables the timeout.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock, 50 MHz, shared with program RAM.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a load.
REQ-006 SHALL have port rx_valid, input, 1 bit: byte-stream valid.
REQ-007 SHALL have port rx_data, input, 8 bits: byte-stream data.
REQ-008 SHALL have port rx_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-009 SHALL have port ram_address, output, 15 bits: program RAM word address.
REQ-010 SHALL have port ram_data, output, 16 bits: program RAM write data.
REQ-011 SHALL have port ram_wren, output, 1 bit: program RAM write enable.
REQ-012 SHALL have port cpu_hold, output, 1 bit: holds CPU clock divider and PC in reset while high.
REQ-013 SHALL have port done, output, 1 bit: load completed and checksum good.
REQ-014 SHALL have port err, output, 1 bit: load failed.
REQ-015 SHALL have port err_code, output, 2 bits: 01 checksum, 10 length, 11 timeout.

Function
REQ-016 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECK, DONE, ERR.
REQ-017 SHALL accept a byte only on a rising clk_in edge where rx_valid && rx_ready.
REQ-018 SHALL drive rx_ready=1 only in LEN_LO, LEN_HI, DATA_LO, DATA_HI and CHECK.
REQ-019 SHALL, on start in IDLE, DONE or ERR, go to LEN_LO and clear done, err, err_code, word index, checksum and timeout counter; start SHALL be ignored in all other states.
REQ-020 SHALL use frame format: length lo, length hi (word count N, little-endian), N words each lo then hi, then one checksum byte.
REQ-021 SHALL define the checksum as XOR of all bytes from length lo through the last data byte; the checksum byte itself SHALL be excluded.
REQ-022 SHALL, after LEN_HI: go to ERR with code 10 if N > DEPTH; go to CHECK if N == 0; otherwise go to DATA_LO.
REQ-023 SHALL, after accepting DATA_HI, enter WRITE for exactly one cycle with ram_wren=1, ram_address=word index, ram_data={hi,lo}.
REQ-024 SHALL, on leaving WRITE, increment the word index and go to CHECK if index == N, else to DATA_LO.
REQ-025 SHALL hold ram_wren=0 in all states except WRITE, and hold ram_address/ram_data at their last values outside WRITE.
REQ-026 SHALL, in CHECK: go to DONE (done=1) if the received byte equals the running XOR, else to ERR with code 01.
REQ-027 SHALL clear the timeout counter on each accepted byte and on entering LEN_LO; it SHALL count only in rx_ready states; reaching TIMEOUT (nonzero) SHALL go to ERR with code 11.
REQ-028 SHALL drive cpu_hold=1 in every state except DONE.
REQ-029 SHALL hold done/err/err_code stable until the next start or reset.
REQ-030 SHALL not consume a byte twice while rx_valid is held through WRITE.

Reset
REQ-031 SHALL, on reset assertion at any time including mid-load, immediately enter IDLE with rx_ready=0, ram_wren=0, ram_address=0, ram_data=0, cpu_hold=1, done=0, err=0, err_code=00, counters=0.
REQ-032 SHALL resume from IDLE on the first clk_in edge after reset deasserts.

Verification
REQ-033 SHALL be verified with: reset, start, stream 02 00 34 12 78 56 0A -> writes [0]=0x1234, [1]=0x5678, each a one-cycle ram_wren; done=1, cpu_hold=0.
REQ-034 SHALL be verified with: same stream with checksum byte 0B -> err=1, err_code=01, cpu_hold=1, done=0.
REQ-035 SHALL be verified with: stream 00 00 00 -> done=1 with no ram_wren pulses.
REQ-036 SHALL be verified with: DEPTH=4, stream 05 00 -> err_code=10 one cycle after LEN_HI, rx_ready=0 thereafter.
REQ-037 SHALL be verified with: TIMEOUT=16, stream 01 00 then 16 idle cycles -> err_code=11; a byte arriving on cycle 15 instead SHALL avoid the error.
REQ-038 SHALL be verified with: reset pulse between DATA_LO and DATA_HI while rx_valid is held high -> IDLE, no write, rx_ready=0; new start reloads correctly.
